regfile_alu_pipe: RTL
=====================

// Module: regfile_alu_pipe
// PURPOSE
//  Two-stage execute unit: parametrised register file and integer ALU behind a
//  valid/ready handshake. Supports RV32I R-type and I-type ALU ops.
//  Stage S1 reads operands (with optional S2 bypass) and computes the ALU result.
//  Stage S2 holds the result and writes it back to the register file on output
//  handshake. Sits between decode and the future memory/writeback stage.
// PARAMETERS
//  DATA_WIDTH  32  operand/register width (power of 2, >=8)
//  REG_COUNT   32  architectural registers; reg 0 hardwired to zero
//  FORWARD     1   1: bypass S2 result into S1; 0: stall S1 on RAW hazard with S2
// PORTS
//  clk        in   1                  clock, all logic on posedge
//  rst        in   1                  reset, synchronous, active-high
//  in_valid   in   1                  instruction offered
//  in_ready   out  1                  instruction accepted when in_valid&in_ready
//  rs1,rs2,rd in   $clog2(REG_COUNT)  source/dest register indices
//  op         in   4                  {funct7[5],funct3}
//  use_imm    in   1                  1: operand B = imm (I-type); 0: operand B = reg[rs2]
//  imm        in   DATA_WIDTH         sign-extended immediate
//  out_valid  out  1                  S2 holds a result
//  out_ready  in   1                  consumer accepts; S2 retires on out_valid&out_ready
//  out_rd     out  $clog2(REG_COUNT)  destination of S2 result
//  out_data   out  DATA_WIDTH         S2 result
//  out_zero   out  1                  out_data == 0
//  out_ovf    out  1                  signed overflow (ADD/SUB only, else 0)
//  out_err    out  1                  illegal op in S2
//  dbg_addr   in   $clog2(REG_COUNT)  debug read index
//  dbg_data   out  DATA_WIDTH         combinational reg[dbg_addr] (0 for index 0)
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: all valids = 0, in_ready = 0 during rst, out_* = 0, all registers = 0.
//    Instructions in flight are dropped with no writeback.
//  Ops (op): 0000 ADD, 1000 SUB, x001 SLL, x010 SLT, x011 SLTU, x100 XOR,
//    0101 SRL, 1101 SRA, x110 OR, x111 AND.
//    op[3]=1 with funct3 in {001,010,011,100,110,111} is illegal:
//    result 0, err=1, still retires and writes rd.
//    With use_imm=1, op[3] is ignored except for funct3=101 (SRAI). SUBI does not exist.
//  Shift amount = operand B[$clog2(DATA_WIDTH)-1:0].
//  SLT/SLTU result is zero-extended 0/1.
//  ovf: ADD: sign(A)==sign(B) && sign(R)!=sign(A). SUB: sign(A)!=sign(B) && sign(R)!=sign(A).
//  Pipeline:
//    Accept at edge N latches into S1.
//    S1 computes and moves to S2 at edge N+1 if S2 is empty or retiring.
//    out_valid is high from N+1. Minimum latency is 2 edges.
//  in_ready = !S1_valid | S1_advance.
//  S1_advance = S1_valid & !hazard_stall & (!S2_valid | out_ready).
//  Writeback: reg[out_rd] <= out_data at the retire edge, if out_rd != 0.
//  Operand read in S1:
//    - if FORWARD=1 and S2_valid and S2.rd==rsX and rsX!=0: use S2 data,
//      else use the register file.
//    - reads of reg 0 always return 0.
//    - a retiring S2 is forwarded in the same cycle, so no bubble.
//  hazard_stall (FORWARD=0 only): S2_valid & S2.rd!=0 & (S2.rd==rs1 | (!use_imm & S2.rd==rs2)).
//    S1 holds until S2 retires, then reads the updated file next cycle (1 bubble).
//  Backpressure: out_ready=0 freezes S2. S1 then freezes when full. in_ready drops.
//    No data is lost or duplicated.
//  Throughput: 1 instr/cycle with FORWARD=1 and out_ready held high.
//  rd=0 instructions compute and retire normally but never write.
// TESTING
//  1. Reset, then write r10=7, r11=5 via ADDI from r0. Run ADD r5,r10,r11 -> out_data=12, dbg r5=12.
//  2. Back-to-back ADDI r1,r0,3 then ADD r2,r1,r1 (FORWARD=1) -> r2=6, no bubble.
//     Same with FORWARD=0 -> r2=6, in_ready low for 1 cycle.
//  3. SUB 0x80000000-1 -> 0x7FFFFFFF, ovf=1. ADD 5+(-5) -> 0, zero=1.
//     SRA 0x80000000>>4 -> 0xF8000000. SLTU 1<0xFFFFFFFF -> 1.
//  4. Hold out_ready=0 for 5 cycles with 3 instrs offered -> in_ready=0 after 2 accepted.
//     On release, all 3 retire in order with correct data.
//  5. ADDI r0,r0,9 -> retires with out_data=9, dbg r0 stays 0.
//     op=1110 (R-type) -> err=1, data 0.
//  6. Assert rst with S1 and S2 full -> next cycle out_valid=0, no register written, all regs read 0.

Source files
------------

// File: rtl/regfile_alu_pipe_if.sv
// Instruction and result channel between decode, the execute pipe and its consumer.
// The master side offers instructions and accepts results; the slave side is the pipe.
interface regfile_alu_pipe_if #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32
);
   logic                          in_valid;
   logic                          in_ready;
   logic [$clog2(REG_COUNT)-1:0]  rs1;
   logic [$clog2(REG_COUNT)-1:0]  rs2;
   logic [$clog2(REG_COUNT)-1:0]  rd;
   logic [3:0]                    op;
   logic                          use_imm;
   logic [DATA_WIDTH-1:0]         imm;
   logic                          out_valid;
   logic                          out_ready;
   logic [$clog2(REG_COUNT)-1:0]  out_rd;
   logic [DATA_WIDTH-1:0]         out_data;
   logic                          out_zero;
   logic                          out_ovf;
   logic                          out_err;

   modport master (
      output in_valid, rs1, rs2, rd, op, use_imm, imm, out_ready,
      input  in_ready, out_valid, out_rd, out_data, out_zero, out_ovf, out_err
   );

   modport slave (
      input  in_valid, rs1, rs2, rd, op, use_imm, imm, out_ready,
      output in_ready, out_valid, out_rd, out_data, out_zero, out_ovf, out_err
   );
endinterface

// File: rtl/regfile_alu_pipe.sv
// Two-stage execute unit: S1 reads operands and runs the ALU, S2 holds the result
// and writes it back to the register file when the consumer takes it.
module regfile_alu_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32,
   parameter int FORWARD    = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   regfile_alu_pipe_if.slave            bus,
   input  logic [$clog2(REG_COUNT)-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0]        dbg_data
);
   localparam int AW  = $clog2(REG_COUNT);
   localparam int SW  = $clog2(DATA_WIDTH);
   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] r_rf [REG_COUNT];

   logic                  r_s1_valid;
   logic [AW-1:0]         r_s1_rs1;
   logic [AW-1:0]         r_s1_rs2;
   logic [AW-1:0]         r_s1_rd;
   logic [3:0]            r_s1_op;
   logic                  r_s1_use_imm;
   logic [DATA_WIDTH-1:0] r_s1_imm;

   logic                  r_s2_valid;
   logic [AW-1:0]         r_s2_rd;
   logic [DATA_WIDTH-1:0] r_s2_data;
   logic                  r_s2_zero;
   logic                  r_s2_ovf;
   logic                  r_s2_err;

   logic [AW-1:0]         w_src   [2];
   logic                  w_match [2];
   logic [DATA_WIDTH-1:0] w_opnd  [2];
   logic                  w_hazard;
   logic                  w_s1_adv;
   logic                  w_retire;
   logic                  w_accept;

   logic [DATA_WIDTH-1:0] w_a;
   logic [DATA_WIDTH-1:0] w_b;
   logic [DATA_WIDTH-1:0] w_sum;
   logic [DATA_WIDTH-1:0] w_diff;
   logic [DATA_WIDTH-1:0] w_res;
   logic [SW-1:0]         w_shamt;
   logic                  w_alt;
   logic                  w_ovf;
   logic                  w_err;

   assign w_src[0] = r_s1_rs1;
   assign w_src[1] = r_s1_rs2;

   // A match against S2 either forwards its result or, without forwarding, stalls S1.
   for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      assign w_match[gi] = r_s2_valid && (r_s2_rd == w_src[gi]) && (w_src[gi] != '0);
      assign w_opnd[gi]  = (w_src[gi] == '0)              ? '0 :
                           ((FORWARD != 0) && w_match[gi]) ? r_s2_data :
                                                             r_rf[w_src[gi]];
   end

   assign w_hazard = (FORWARD == 0) && (w_match[0] || (!r_s1_use_imm && w_match[1]));
   assign w_retire = r_s2_valid && bus.out_ready;
   assign w_s1_adv = r_s1_valid && !w_hazard && (!r_s2_valid || bus.out_ready);
   assign bus.in_ready = !rst && (!r_s1_valid || w_s1_adv);
   assign w_accept = bus.in_valid && bus.in_ready;

   assign w_a = w_opnd[0];

   always_comb begin
      w_b     = r_s1_use_imm ? r_s1_imm : w_opnd[1];
      // Immediate forms only honour the alternate bit for SRAI.
      w_alt   = r_s1_op[3] && (!r_s1_use_imm || (r_s1_op[2:0] == 3'b101));
      w_shamt = w_b[SW-1:0];
      w_sum   = w_a + w_b;
      w_diff  = w_a - w_b;
      w_res   = '0;
      w_ovf   = 1'b0;
      w_err   = w_alt && (r_s1_op[2:0] != 3'b000) && (r_s1_op[2:0] != 3'b101);
      case (r_s1_op[2:0])
         3'b000: begin
            if (w_alt) begin
               w_res = w_diff;
               w_ovf = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
            end else begin
               w_res = w_sum;
               w_ovf = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
            end
         end
         3'b001:  w_res = w_a << w_shamt;
         3'b010:  w_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
         3'b011:  w_res = {{(DATA_WIDTH-1){1'b0}}, (w_a < w_b)};
         3'b100:  w_res = w_a ^ w_b;
         3'b101:  w_res = w_alt ? $unsigned($signed(w_a) >>> w_shamt) : (w_a >> w_shamt);
         3'b110:  w_res = w_a | w_b;
         default: w_res = w_a & w_b;
      endcase
      if (w_err) begin
         w_res = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid   <= 1'b0;
         r_s1_rs1     <= '0;
         r_s1_rs2     <= '0;
         r_s1_rd      <= '0;
         r_s1_op      <= '0;
         r_s1_use_imm <= 1'b0;
         r_s1_imm     <= '0;
      end else if (w_accept) begin
         r_s1_valid   <= 1'b1;
         r_s1_rs1     <= bus.rs1;
         r_s1_rs2     <= bus.rs2;
         r_s1_rd      <= bus.rd;
         r_s1_op      <= bus.op;
         r_s1_use_imm <= bus.use_imm;
         r_s1_imm     <= bus.imm;
      end else if (w_s1_adv) begin
         r_s1_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_rd    <= '0;
         r_s2_data  <= '0;
         r_s2_zero  <= 1'b0;
         r_s2_ovf   <= 1'b0;
         r_s2_err   <= 1'b0;
      end else if (w_s1_adv) begin
         r_s2_valid <= 1'b1;
         r_s2_rd    <= r_s1_rd;
         r_s2_data  <= w_res;
         r_s2_zero  <= (w_res == '0);
         r_s2_ovf   <= w_ovf;
         r_s2_err   <= w_err;
      end else if (w_retire) begin
         r_s2_valid <= 1'b0;
      end
   end

   // Register 0 is never written, so it reads back as zero without special storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_rf[i] <= '0;
         end
      end else if (w_retire && (r_s2_rd != '0)) begin
         r_rf[r_s2_rd] <= r_s2_data;
      end
   end

   assign bus.out_valid = r_s2_valid;
   assign bus.out_rd    = r_s2_rd;
   assign bus.out_data  = r_s2_data;
   assign bus.out_zero  = r_s2_zero;
   assign bus.out_ovf   = r_s2_ovf;
   assign bus.out_err   = r_s2_err;
   assign dbg_data      = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];
endmodule
